unidade_entrada_saida: RTL and testbench
========================================

# unidade_entrada_saida

Sequential I/O unit driven by the control unit's `sel_clock` code. It sits directly downstream of instruction decode, alongside the datapath.
- IN: stalls the processor until the operator confirms switch input with a debounced button press, then delivers the switch value for register write.
- OUT: latches a register operand into the display register.
- FINISH: halts the core until reset.

## Interface
Parameters:
- `DATA_W`, 32, datapath / display width
- `SW_W`, 16, switch input width (≤ DATA_W)
- `DEBOUNCE_CYCLES`, 4, consecutive stable cycles required to accept a button level change (board build overrides, e.g. 500000)

Ports:
- Clocking: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sel_clock`  in  2  from control unit: 00 none, 01 OUT, 10 IN, 11 FINISH
- `out_data`  in  DATA_W  register operand for OUT
- `switches`  in  SW_W  raw board switches (assumed quasi-static)
- `btn_enter`  in  1  raw, asynchronous, bouncing confirm button
- `stall`  out  1  freeze PC and state writes this cycle
- `in_data`  out  DATA_W  captured switches, zero-extended
- `in_valid`  out  1  one-cycle pulse: `in_data` valid, regWrite permitted
- `display`  out  DATA_W  last OUT value
- `display_valid`  out  1  sticky, set by first OUT
- `halted`  out  1  FINISH executed

## Operation
- Button path: 2-FF synchronizer, then a counter.
  - Counter clears whenever the synchronized level equals the debounced level.
  - When the levels differ for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value.
  - A rising edge of the debounced level gives a one-cycle `press` pulse.
- FSM states: IDLE, IN_WAIT, IN_DONE, HALT.
- IDLE:
  - `sel_clock`=01: `display`<=`out_data` and `display_valid`<=1 at the next edge; no stall; stay in IDLE.
  - `sel_clock`=10: go to IN_WAIT.
  - `sel_clock`=11: go to HALT.
  - `sel_clock`=00: stay in IDLE.
- IN_WAIT: on `press`, `in_data`<={zeros, `switches`} and go to IN_DONE. Otherwise stay.
- IN_DONE: `in_valid`=1. `sel_clock` is ignored (it still reads 10 for the same instruction). Go to IDLE.
- HALT: `halted`=1. Absorbing; only `rst` exits. Button and `sel_clock` are ignored.
- `stall` (combinational) = !`rst` and ((IDLE and `sel_clock`[1]) or IN_WAIT or HALT).
- Only a press whose rising edge occurs while in IN_WAIT is accepted.
  - A button already held on entry must debounce low, then high again.
  - A `press` pulse coinciding with the IDLE→IN_WAIT transition cycle is discarded.
- `in_data` holds its value until the next accepted IN.

## Timing
- Reset values: state IDLE; `stall` 0; `in_data` 0; `in_valid` 0; `display` 0; `display_valid` 0; `halted` 0; synchronizer, debounced level and counter 0.
- OUT: `display` updates at the edge that ends the OUT cycle. Latency 1. Zero stall cycles.
- IN/FINISH: `stall` is high in the same cycle `sel_clock` is presented (no bubble).
- IN completion:
  - `press` fires 2+DEBOUNCE_CYCLES edges after `btn_enter` rises and stays stable.
  - The IN_WAIT→IN_DONE edge follows.
  - The IN_DONE cycle has `stall`=0 and `in_valid`=1.
  - Minimum IN duration: 1 + (2+DEBOUNCE_CYCLES) + 1 cycles.
- `halted` rises one edge after FINISH is presented.
- `rst` mid-operation (any state): immediate IDLE, `stall` forced 0 asynchronously, pending IN abandoned, `in_valid` 0.

## Structure
- Shared package `es_pkg`:
  - `sel_clock` code constants SEL_NONE, SEL_OUT, SEL_IN, SEL_FINISH (shared with the control unit)
  - FSM state typedef
- Sub-module `debounce`: synchronizer, counter, level and `press` edge output; parameterized by DEBOUNCE_CYCLES.
- FSM and data registers live in the top module.

## Test plan
- Reset: assert `rst` with `sel_clock`=10 and `btn_enter`=1 → all outputs 0, `stall`=0. Release → state IDLE.
- OUT: `out_data`=0x0000002A, `sel_clock`=01 for one cycle → `display`=0x2A and `display_valid`=1 after one edge; `stall` never 1.
- IN: `switches`=0x00F3, `sel_clock`=10, clean press held 10 cycles with DEBOUNCE_CYCLES=4 → `stall`=1 from the IN cycle; a single `in_valid` pulse with `in_data`=0x000000F3 and `stall`=0 in that cycle; IN lasts exactly 8 cycles when the press starts at IN entry.
- Bounce: `btn_enter` toggles every 2 cycles for 12 cycles, then stays low → no `in_valid`, `stall` stays 1.
- Held button: `btn_enter` already high (debounced) when IN is issued → no accept; release ≥6 cycles then press → accept exactly once.
- FINISH then reset: `sel_clock`=11 → `halted`=1 next edge, `stall`=1 through repeated presses; assert `rst` → `stall`=0 and `halted`=0 immediately.

Source files
------------

// File: rtl/es_pkg.sv
// rtl/es_pkg.sv - sel_clock codes and FSM state type shared by the I/O unit and control unit
package es_pkg;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_OUT    = 2'b01;
    localparam logic [1:0] SEL_IN     = 2'b10;
    localparam logic [1:0] SEL_FINISH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_IN_WAIT = 2'b01,
        ST_IN_DONE = 2'b10,
        ST_HALT    = 2'b11
    } es_state_t;

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - button synchronizer and debouncer with one-cycle rising-edge press pulse
module debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // The current cycle is the last of DEBOUNCE_CYCLES consecutive mismatches.
    assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= flip && sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/unidade_entrada_saida.sv
// rtl/unidade_entrada_saida.sv - I/O unit: switch input with operator confirm, display output, halt
module unidade_entrada_saida
    import es_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sel_clock,
    input  logic [DATA_W-1:0] out_data,
    input  logic [SW_W-1:0]   switches,
    input  logic              btn_enter,
    output logic              stall,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic [DATA_W-1:0] display,
    output logic              display_valid,
    output logic              halted
);

    es_state_t state;
    es_state_t state_next;
    logic      press;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_enter),
        .press (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (sel_clock == SEL_IN) begin
                    state_next = ST_IN_WAIT;
                end else if (sel_clock == SEL_FINISH) begin
                    state_next = ST_HALT;
                end
            end
            ST_IN_WAIT: begin
                if (press) begin
                    state_next = ST_IN_DONE;
                end
            end
            // sel_clock still shows this IN instruction here, so it is not decoded.
            ST_IN_DONE: state_next = ST_IDLE;
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        in_valid = 1'b0;
        halted   = 1'b0;
        case (state)
            ST_IDLE:    stall    = sel_clock[1];
            ST_IN_WAIT: stall    = 1'b1;
            ST_IN_DONE: in_valid = 1'b1;
            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_data       <= '0;
            display       <= '0;
            display_valid <= 1'b0;
        end else begin
            if (state == ST_IN_WAIT && press) begin
                in_data <= DATA_W'(switches);
            end
            if (state == ST_IDLE && sel_clock == SEL_OUT) begin
                display       <= out_data;
                display_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unidade_entrada_saida.sv
// tb/tb_unidade_entrada_saida.sv - self-checking bench for unidade_entrada_saida against a behavioural model
module tb_unidade_entrada_saida;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;
    localparam int DB     = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        sel_clock;
    logic [DATA_W-1:0] out_data;
    logic [SW_W-1:0]   switches;
    logic              btn_enter;
    logic              stall;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] display;
    logic              display_valid;
    logic              halted;

    unidade_entrada_saida #(
        .DATA_W(DATA_W),
        .SW_W(SW_W),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel_clock     (sel_clock),
        .out_data      (out_data),
        .switches      (switches),
        .btn_enter     (btn_enter),
        .stall         (stall),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .display       (display),
        .display_valid (display_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: button pipeline as sample history, instruction progress as flags.
    bit        m_b1, m_b2, m_level, m_press;
    bit        s_hist[$];
    bit        m_wait, m_done, m_halt;
    bit [31:0] m_in_data, m_disp;
    bit        m_dvalid;
    bit        obs_stall, obs_valid;

    function automatic void model_reset();
        m_b1 = 0; m_b2 = 0; m_level = 0; m_press = 0;
        s_hist.delete();
        m_wait = 0; m_done = 0; m_halt = 0;
        m_in_data = 0; m_disp = 0; m_dvalid = 0;
    endfunction

    function automatic bit model_stall();
        bit idle;
        idle = !m_wait && !m_done && !m_halt;
        return (idle && sel_clock[1]) || m_wait || m_halt;
    endfunction

    function automatic void model_edge();
        bit all_diff;
        bit flip;
        s_hist.push_back(m_b2);
        if (s_hist.size() > DB) void'(s_hist.pop_front());
        all_diff = (s_hist.size() == DB);
        foreach (s_hist[i]) if (s_hist[i] == m_level) all_diff = 0;
        flip = all_diff;
        if (m_halt) begin
        end else if (m_done) begin
            m_done = 0;
        end else if (m_wait) begin
            if (m_press) begin
                m_in_data = 32'(switches);
                m_wait = 0;
                m_done = 1;
            end
        end else begin
            case (sel_clock)
                2'b01: begin m_disp = out_data; m_dvalid = 1; end
                2'b10: m_wait = 1;
                2'b11: m_halt = 1;
                default: ;
            endcase
        end
        m_press = flip && !m_level;
        if (flip) m_level = !m_level;
        m_b2 = m_b1;
        m_b1 = btn_enter;
    endfunction

    task automatic cycle(input logic [1:0] sel, input logic btn);
        sel_clock = sel;
        btn_enter = btn;
        @(negedge clk);
        obs_stall = stall;
        obs_valid = in_valid;
        chk("stall", 32'(stall), 32'(model_stall()));
        chk("in_valid", 32'(in_valid), 32'(m_done));
        chk("in_data", in_data, m_in_data);
        chk("display", display, m_disp);
        chk("display_valid", 32'(display_valid), 32'(m_dvalid));
        chk("halted", 32'(halted), 32'(m_halt));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_in_valid"}, 32'(in_valid), 32'd0);
        chk({tag, "_in_data"}, in_data, 32'd0);
        chk({tag, "_display"}, display, 32'd0);
        chk({tag, "_display_valid"}, 32'(display_valid), 32'd0);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int n;
    int valids;
    int stall_seen;
    int btn_left;
    bit btn_rand;
    int halt_cycles;
    logic [1:0] s;

    initial begin
        rst = 1'b1;
        sel_clock = 2'b10;
        btn_enter = 1'b1;
        out_data = '0;
        switches = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // OUT
        out_data = 32'h0000_002A;
        stall_seen = 0;
        cycle(2'b01, 1'b0);
        stall_seen += int'(obs_stall);
        cycle(2'b00, 1'b0);
        stall_seen += int'(obs_stall);
        chk("out_display", display, 32'h0000_002A);
        chk("out_no_stall", 32'(stall_seen), 32'd0);

        // IN with press starting at IN entry: exactly 8 cycles
        switches = 16'h00F3;
        for (int i = 0; i < 4; i++) cycle(2'b00, 1'b0);
        n = 0;
        do begin
            cycle(2'b10, 1'b1);
            n++;
        end while (!obs_valid && n < 40);
        chk("in_length", 32'(n), 32'd8);
        chk("in_data_f3", in_data, 32'h0000_00F3);
        chk("in_done_stall", 32'(obs_stall), 32'd0);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0);

        // Bounce never settles
        valids = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(2'b10, 1'((i / 2) % 2));
            valids += int'(obs_valid);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(2'b10, 1'b0);
            valids += int'(obs_valid);
        end
        chk("bounce_no_valid", 32'(valids), 32'd0);
        chk("bounce_stall", 32'(obs_stall), 32'd1);
        n = 0;
        do begin
            cycle(2'b10, 1'b1);
            n++;
        end while (!obs_valid && n < 40);
        chk("bounce_recover", 32'(obs_valid), 32'd1);
        for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0);

        // Held button on IN entry
        switches = 16'hBEEF;
        for (int i = 0; i < 10; i++) cycle(2'b00, 1'b1);
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(2'b10, 1'b1);
            valids += int'(obs_valid);
        end
        chk("held_no_accept", 32'(valids), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(2'b10, 1'b0);
            valids += int'(obs_valid);
        end
        n = 0;
        do begin
            cycle(2'b10, 1'b1);
            valids += int'(obs_valid);
            n++;
        end while (!obs_valid && n < 40);
        for (int i = 0; i < 10; i++) begin
            cycle(2'b00, 1'b1);
            valids += int'(obs_valid);
        end
        chk("held_accept_once", 32'(valids), 32'd1);
        chk("held_in_data", in_data, 32'h0000_BEEF);
        for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0);

        // FINISH then reset
        cycle(2'b11, 1'b0);
        chk("finish_halted", 32'(halted), 32'd1);
        stall_seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(2'($urandom_range(0, 3)), 1'((i / 8) % 2));
            stall_seen += int'(obs_stall);
        end
        chk("halt_stall_all", 32'(stall_seen), 32'd30);
        do_reset("halt_reset");

        // Randomised CPU-like traffic
        btn_left = 0;
        btn_rand = 0;
        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_left == 0) begin
                btn_rand = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            out_data = $urandom;
            if ($urandom_range(0, 9) == 0) switches = 16'($urandom);
            if (m_wait || m_done) begin
                s = 2'b10;
            end else if (m_halt) begin
                s = 2'($urandom_range(0, 3));
            end else begin
                n = $urandom_range(0, 99);
                s = (n < 40) ? 2'b00 : (n < 70) ? 2'b01 : (n < 98) ? 2'b10 : 2'b11;
            end
            if (m_halt) halt_cycles++;
            if (halt_cycles > 15) begin
                halt_cycles = 0;
                do_reset("rand_reset");
            end else begin
                cycle(s, btn_rand);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
